// File: rtl/as5600_angle_tracker.sv
// Polls the AS5600 read engine and reduces each result to mechanical/electrical angle,
// a signed turn count and, when ANGLE_TRACKER_SPEED_EN is defined, a windowed speed sum.
module as5600_angle_tracker #(
   parameter logic [31:0] POLL_DIV     = 32'd100000,
   parameter logic [31:0] TIMEOUT      = 32'd50000,
   parameter logic [7:0]  POLE_PAIR    = 8'd7,
   parameter logic [11:0] ANGLE_OFFSET = 12'd0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        i2c_start,
   input  logic        i2c_ready,
   input  logic        i2c_done,
   input  logic [15:0] i2c_regout,
   output logic        angle_valid,
   output logic [11:0] mech_angle,
   output logic [11:0] elec_angle,
   output logic [15:0] turns,
   output logic [15:0] speed,
   output logic        speed_valid,
   output logic        fault,
   output logic [7:0]  fault_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT, CALC, UPDATE} state_t;

   state_t      state_reg, state_next;
   logic [31:0] poll_cnt_reg;
   logic        tick;
   logic        pending_reg, pending_next;
   logic        start_reg, start_next;
   logic [31:0] tmo_cnt_reg, tmo_cnt_next;
   logic        fault_reg, fault_next;
   logic [7:0]  fault_cnt_reg, fault_cnt_next;
   logic [11:0] raw_reg, raw_next;
   logic [11:0] m_calc, elec_calc;
   logic [11:0] prev_reg, mech_reg, elec_reg;
   logic [15:0] turns_reg, turns_calc;
   logic        first_reg, valid_reg;
   logic        unused_regout_bits;

   assign unused_regout_bits = ^i2c_regout[15:12];

   assign tick = (poll_cnt_reg == POLL_DIV - 32'd1);

   always_ff @(posedge clk) begin
      if (rst)
         poll_cnt_reg <= '0;
      else if (tick)
         poll_cnt_reg <= '0;
      else
         poll_cnt_reg <= poll_cnt_reg + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         pending_reg   <= 1'b0;
         start_reg     <= 1'b0;
         tmo_cnt_reg   <= '0;
         fault_reg     <= 1'b0;
         fault_cnt_reg <= '0;
         raw_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         pending_reg   <= pending_next;
         start_reg     <= start_next;
         tmo_cnt_reg   <= tmo_cnt_next;
         fault_reg     <= fault_next;
         fault_cnt_reg <= fault_cnt_next;
         raw_reg       <= raw_next;
      end
   end

   // A tick in the same cycle as an IDLE launch is consumed directly, so the
   // request goes out the cycle after the tick.
   always_comb begin
      state_next     = state_reg;
      pending_next   = pending_reg | tick;
      start_next     = 1'b0;
      tmo_cnt_next   = tmo_cnt_reg;
      fault_next     = 1'b0;
      fault_cnt_next = fault_cnt_reg;
      raw_next       = raw_reg;
      case (state_reg)
         IDLE: begin
            if ((pending_reg || tick) && i2c_ready) begin
               start_next   = 1'b1;
               pending_next = 1'b0;
               tmo_cnt_next = '0;
               state_next   = WAIT;
            end
         end
         WAIT: begin
            if (i2c_done) begin
               raw_next   = i2c_regout[11:0];
               state_next = CALC;
            end else if (tmo_cnt_reg == TIMEOUT - 32'd1) begin
               fault_next = 1'b1;
               if (fault_cnt_reg != 8'hFF)
                  fault_cnt_next = fault_cnt_reg + 8'd1;
               state_next = IDLE;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 32'd1;
            end
         end
         CALC:    state_next = UPDATE;
         UPDATE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign m_calc    = raw_reg - ANGLE_OFFSET;
   assign elec_calc = m_calc * {4'd0, POLE_PAIR};

   always_comb begin
      turns_calc = turns_reg;
      if (!first_reg) begin
         if (prev_reg >= 12'hC00 && m_calc < 12'h400)
            turns_calc = turns_reg + 16'd1;
         else if (prev_reg < 12'h400 && m_calc >= 12'hC00)
            turns_calc = turns_reg - 16'd1;
      end
   end

   // Results are registered on the CALC edge so they are visible (with angle_valid)
   // during UPDATE, two cycles after i2c_done.
   always_ff @(posedge clk) begin
      if (rst) begin
         mech_reg  <= '0;
         elec_reg  <= '0;
         turns_reg <= '0;
         prev_reg  <= '0;
         first_reg <= 1'b1;
         valid_reg <= 1'b0;
      end else if (state_reg == CALC) begin
         mech_reg  <= m_calc;
         elec_reg  <= elec_calc;
         turns_reg <= turns_calc;
         prev_reg  <= m_calc;
         first_reg <= 1'b0;
         valid_reg <= 1'b1;
      end else begin
         valid_reg <= 1'b0;
      end
   end

`ifdef ANGLE_TRACKER_SPEED_EN
   logic [11:0] delta_calc;
   logic [15:0] delta_ext;
   logic [15:0] acc_reg, speed_reg;
   logic [3:0]  sample_cnt_reg;
   logic        speed_valid_reg;

   assign delta_calc = first_reg ? 12'd0 : (m_calc - prev_reg);
   assign delta_ext  = {{4{delta_calc[11]}}, delta_calc};

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg         <= '0;
         speed_reg       <= '0;
         sample_cnt_reg  <= '0;
         speed_valid_reg <= 1'b0;
      end else if (state_reg == CALC) begin
         sample_cnt_reg <= sample_cnt_reg + 4'd1;
         if (sample_cnt_reg == 4'd15) begin
            speed_reg       <= acc_reg + delta_ext;
            acc_reg         <= '0;
            speed_valid_reg <= 1'b1;
         end else begin
            acc_reg         <= acc_reg + delta_ext;
            speed_valid_reg <= 1'b0;
         end
      end else begin
         speed_valid_reg <= 1'b0;
      end
   end

   assign speed       = speed_reg;
   assign speed_valid = speed_valid_reg;
`else
   assign speed       = '0;
   assign speed_valid = 1'b0;
`endif

   assign i2c_start   = start_reg;
   assign angle_valid = valid_reg;
   assign mech_angle  = mech_reg;
   assign elec_angle  = elec_reg;
   assign turns       = turns_reg;
   assign fault       = fault_reg;
   assign fault_cnt   = fault_cnt_reg;

endmodule

// File: tb/tb_as5600_angle_tracker.sv
// Scoreboard bench for as5600_angle_tracker: a zero-offset and a 0x200-offset instance
// share one read-engine model; expected angles are queued when i2c_done is driven.
module tb_as5600_angle_tracker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i2c_ready = 1'b1;
   logic        i2c_done = 1'b0;
   logic [15:0] i2c_regout = 16'h0;

   logic        i2c_start, angle_valid, speed_valid, fault;
   logic [11:0] mech_angle, elec_angle;
   logic [15:0] turns, speed;
   logic [7:0]  fault_cnt;

   logic        i2c_start_o, angle_valid_o, speed_valid_o, fault_o;
   logic [11:0] mech_angle_o, elec_angle_o;
   logic [15:0] turns_o, speed_o;
   logic [7:0]  fault_cnt_o;

   as5600_angle_tracker #(.POLL_DIV(32'd100), .TIMEOUT(32'd500), .POLE_PAIR(8'd7), .ANGLE_OFFSET(12'h000)) u_dut (
      .clk(clk), .rst(rst), .i2c_start(i2c_start), .i2c_ready(i2c_ready), .i2c_done(i2c_done),
      .i2c_regout(i2c_regout), .angle_valid(angle_valid), .mech_angle(mech_angle), .elec_angle(elec_angle),
      .turns(turns), .speed(speed), .speed_valid(speed_valid), .fault(fault), .fault_cnt(fault_cnt));

   as5600_angle_tracker #(.POLL_DIV(32'd100), .TIMEOUT(32'd500), .POLE_PAIR(8'd7), .ANGLE_OFFSET(12'h200)) u_off (
      .clk(clk), .rst(rst), .i2c_start(i2c_start_o), .i2c_ready(i2c_ready), .i2c_done(i2c_done),
      .i2c_regout(i2c_regout), .angle_valid(angle_valid_o), .mech_angle(mech_angle_o), .elec_angle(elec_angle_o),
      .turns(turns_o), .speed(speed_o), .speed_valid(speed_valid_o), .fault(fault_o), .fault_cnt(fault_cnt_o));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int rel = 0;
   int last_start = 0;
   int prev_start = 0;
   int start_count = 0;
   bit fault_ok = 1'b0;

   typedef struct {
      int          cyc;
      logic [11:0] m, e, mo, eo;
      logic [15:0] t, to, spd;
      logic        sv;
   } exp_t;

   exp_t sbq[$];
   exp_t mx;

   // reference model state
   logic [11:0] mdl_prev[2];
   logic [11:0] mdl_m[2];
   logic [15:0] mdl_turns[2];
   bit          mdl_first;
   logic [15:0] mdl_acc, mdl_speed;
   int          mdl_cnt;
   logic [7:0]  mdl_fcnt;

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mdl_prev[k]  = 12'h0;
         mdl_m[k]     = 12'h0;
         mdl_turns[k] = 16'h0;
      end
      mdl_first = 1'b1;
      mdl_acc   = 16'h0;
      mdl_speed = 16'h0;
      mdl_cnt   = 0;
      mdl_fcnt  = 8'h0;
   endtask

   task automatic model_push(input logic [11:0] raw, input int ec);
      exp_t        x;
      logic [11:0] m, e, offs, d;
      logic [15:0] dx;
      d = 12'h0;
      for (int k = 0; k < 2; k++) begin
         offs = (k == 0) ? 12'h000 : 12'h200;
         m = raw - offs;
         e = m * 12'd7;
         if (k == 0) d = mdl_first ? 12'h0 : (m - mdl_prev[0]);
         if (!mdl_first) begin
            if (mdl_prev[k] >= 12'hC00 && m < 12'h400)
               mdl_turns[k] = mdl_turns[k] + 16'd1;
            else if (mdl_prev[k] < 12'h400 && m >= 12'hC00)
               mdl_turns[k] = mdl_turns[k] - 16'd1;
         end
         mdl_prev[k] = m;
         mdl_m[k]    = m;
         if (k == 0) begin x.m = m; x.e = e; x.t = mdl_turns[0]; end
         else begin x.mo = m; x.eo = e; x.to = mdl_turns[1]; end
      end
`ifdef ANGLE_TRACKER_SPEED_EN
      dx = {{4{d[11]}}, d};
      if (mdl_cnt == 15) begin
         mdl_speed = mdl_acc + dx;
         mdl_acc   = 16'h0;
         mdl_cnt   = 0;
         x.sv      = 1'b1;
      end else begin
         mdl_acc = mdl_acc + dx;
         mdl_cnt = mdl_cnt + 1;
         x.sv    = 1'b0;
      end
      x.spd = mdl_speed;
`else
      dx    = 16'h0;
      x.sv  = 1'b0;
      x.spd = dx;
`endif
      mdl_first = 1'b0;
      x.cyc = ec;
      sbq.push_back(x);
   endtask

   // output monitor: pops the scoreboard on every angle_valid
   always @(negedge clk) begin
      if (i2c_start === 1'b1) start_count++;
      if (angle_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_angle_valid cycle %0d mech %h", cyc, mech_angle);
         end else begin
            mx = sbq.pop_front();
            checks++;
            if (cyc !== mx.cyc || mech_angle !== mx.m || elec_angle !== mx.e || turns !== mx.t ||
                mech_angle_o !== mx.mo || elec_angle_o !== mx.eo || turns_o !== mx.to ||
                speed !== mx.spd || speed_valid !== mx.sv || angle_valid_o !== 1'b1) begin
               errors++;
               $display("FAIL sample got cyc %0d mech %h elec %h turns %h mech_o %h elec_o %h turns_o %h speed %0d sv %b want cyc %0d mech %h elec %h turns %h mech_o %h elec_o %h turns_o %h speed %0d sv %b",
                        cyc, mech_angle, elec_angle, turns, mech_angle_o, elec_angle_o, turns_o, speed, speed_valid,
                        mx.cyc, mx.m, mx.e, mx.t, mx.mo, mx.eo, mx.to, mx.spd, mx.sv);
            end
         end
      end
      if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
         checks++; errors++;
         $display("FAIL angle_valid_missing cycle %0d expected at %0d", cyc, sbq[0].cyc);
         void'(sbq.pop_front());
      end
      if ((fault === 1'b1 || fault_o === 1'b1) && !fault_ok) begin
         checks++; errors++;
         $display("FAIL unexpected_fault cycle %0d", cyc);
      end
      if (i2c_start !== i2c_start_o) begin
         checks++; errors++;
         $display("FAIL start_mismatch cycle %0d got %b want %b", cyc, i2c_start_o, i2c_start);
      end
   end

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (i2c_start === 1'b1) begin
            ok = 1'b1;
            prev_start = last_start;
            last_start = cyc;
            break;
         end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL start_timeout got no i2c_start want one within 400 cycles");
      end
   endtask

   task automatic answer(input logic [15:0] rv, input int dly);
      repeat (dly) @(posedge clk);
      #1;
      i2c_done   = 1'b1;
      i2c_regout = rv;
      model_push(rv[11:0], cyc + 2);
      @(posedge clk);
      #1;
      i2c_done   = 1'b0;
      i2c_regout = 16'h0;
   endtask

   task automatic do_read(input logic [15:0] rv);
      bit ok;
      wait_start(ok);
      if (ok) answer(rv, 40);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rel = cyc;
      model_reset();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({i2c_start, angle_valid, fault, speed_valid} !== 4'b0000) begin
         errors++; $display("FAIL reset_pulses got %b want 0000", {i2c_start, angle_valid, fault, speed_valid});
      end
      checks++;
      if ({mech_angle, elec_angle} !== 24'h0) begin
         errors++; $display("FAIL reset_angles got %h want 000000", {mech_angle, elec_angle});
      end
      checks++;
      if ({turns, speed, fault_cnt} !== 40'h0) begin
         errors++; $display("FAIL reset_counts got %h want 0", {turns, speed, fault_cnt});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      rel = cyc;
      model_reset();
   endtask

   task automatic test_basic();
      bit ok;
      wait_start(ok);
      checks++;
      if (last_start !== rel + 100) begin
         errors++; $display("FAIL first_start got cycle %0d want %0d", last_start, rel + 100);
      end
      if (ok) answer(16'hF123, 40);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (mech_angle !== 12'h123 || elec_angle !== 12'h7F5) begin
         errors++; $display("FAIL basic_angle got %h/%h want 123/7f5", mech_angle, elec_angle);
      end
      do_read(16'hF123);
      checks++;
      if (last_start - prev_start !== 100) begin
         errors++; $display("FAIL poll_period got %0d want 100", last_start - prev_start);
      end
   endtask

   task automatic test_offset();
      do_read(16'h0100);
      checks++;
      if (mech_angle_o !== 12'hF00 || mech_angle !== 12'h100) begin
         errors++; $display("FAIL offset got %h/%h want f00/100", mech_angle_o, mech_angle);
      end
   endtask

   task automatic test_wrap();
      reset_pulse();
      do_read(16'h0F80);
      checks++;
      if (turns !== 16'd0) begin errors++; $display("FAIL wrap_first got %0d want 0", turns); end
      do_read(16'h0010);
      checks++;
      if (turns !== 16'd1) begin errors++; $display("FAIL wrap_up got %0d want 1", turns); end
      do_read(16'h0F80);
      checks++;
      if (turns !== 16'd0) begin errors++; $display("FAIL wrap_down got %0d want 0", turns); end
   endtask

   task automatic test_timeout();
      bit ok;
      bit seen;
      int s;
      int f;
      fault_ok = 1'b1;
      wait_start(ok);
      s = last_start;
      seen = 1'b0;
      f = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (fault === 1'b1) begin seen = 1'b1; f = cyc; break; end
      end
      checks++;
      if (!seen || f - s !== 500) begin
         errors++; $display("FAIL timeout_time got seen %b delay %0d want delay 500", seen, f - s);
      end
      mdl_fcnt = mdl_fcnt + 8'd1;
      checks++;
      if (fault_cnt !== mdl_fcnt || fault_cnt_o !== mdl_fcnt) begin
         errors++; $display("FAIL fault_cnt got %0d/%0d want %0d", fault_cnt, fault_cnt_o, mdl_fcnt);
      end
      checks++;
      if (mech_angle !== mdl_m[0] || turns !== mdl_turns[0] || angle_valid !== 1'b0) begin
         errors++; $display("FAIL timeout_hold got %h %h %b want %h %h 0", mech_angle, turns, angle_valid, mdl_m[0], mdl_turns[0]);
      end
      // stray completion while IDLE
      i2c_done   = 1'b1;
      i2c_regout = 16'hF555;
      @(posedge clk); #1;
      i2c_done   = 1'b0;
      i2c_regout = 16'h0;
      fault_ok   = 1'b0;
      wait_start(ok);
      checks++;
      if (last_start !== f + 1) begin
         errors++; $display("FAIL retry_start got cycle %0d want %0d", last_start, f + 1);
      end
      if (ok) answer(16'h0321, 40);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_ready_hold();
      bit ok;
      int sc0;
      int r;
      i2c_ready = 1'b0;
      sc0 = start_count;
      while (((cyc - rel) % 100) != 99) begin
         @(posedge clk); #1;
      end
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (start_count !== sc0) begin
         errors++; $display("FAIL ready_hold got %0d starts want 0", start_count - sc0);
      end
      i2c_ready = 1'b1;
      r = cyc;
      wait_start(ok);
      checks++;
      if (last_start !== r + 1) begin
         errors++; $display("FAIL ready_release got cycle %0d want %0d", last_start, r + 1);
      end
      if (ok) answer(16'h0ABC, 40);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_in_wait();
      bit ok;
      wait_start(ok);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({i2c_start, angle_valid, fault, mech_angle, elec_angle, turns, fault_cnt, speed} !== 67'h0) begin
         errors++; $display("FAIL reset_wait got start %b mech %h turns %h fcnt %0d speed %0d want all 0",
                            i2c_start, mech_angle, turns, fault_cnt, speed);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      rel = cyc;
      model_reset();
      // late completion from the aborted read
      i2c_done   = 1'b1;
      i2c_regout = 16'hF777;
      @(posedge clk); #1;
      i2c_done   = 1'b0;
      i2c_regout = 16'h0;
      wait_start(ok);
      checks++;
      if (last_start !== rel + 100) begin
         errors++; $display("FAIL post_reset_start got cycle %0d want %0d", last_start, rel + 100);
      end
      if (ok) answer(16'hF456, 40);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (mech_angle !== 12'h456 || turns !== 16'd0) begin
         errors++; $display("FAIL post_reset_read got %h/%0d want 456/0", mech_angle, turns);
      end
   endtask

   task automatic test_speed();
      reset_pulse();
      for (int i = 0; i < 32; i++) begin
         do_read(16'(i * 16));
         if (i == 15 || i == 31) begin
            checks++;
`ifdef ANGLE_TRACKER_SPEED_EN
            if (speed !== ((i == 15) ? 16'd240 : 16'd256)) begin
               errors++; $display("FAIL speed_window got %0d want %0d", speed, (i == 15) ? 240 : 256);
            end
`else
            if (speed !== 16'd0) begin
               errors++; $display("FAIL speed_disabled got %0d want 0", speed);
            end
`endif
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_offset();
      test_wrap();
      test_timeout();
      test_ready_hold();
      test_reset_in_wait();
      test_speed();
      repeat (5) @(posedge clk);
      checks++;
      if (sbq.size() !== 0) begin
         errors++; $display("FAIL scoreboard_drain got %0d left want 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got no finish want finish before 2000000");
      $fatal(1, "watchdog");
   end

endmodule
